// File: rtl/add_sub_exec.sv
// add_sub_exec: two-stage execute pipeline for MIPS64 add/subtract ops.
// S1 registers the adder operands, with operand B already inverted for subtracts.
// The external adder is combinational and is driven straight from S1.
// S2 registers the adder result and applies 32-bit sign extension and the overflow-trap rules.
// S2 then presents the result to writeback over a valid/ready handshake.
module add_sub_exec #(
    parameter int WIDTH   = 64,
    parameter int TAG_W   = 5,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic             p_clk,
    input  logic             p_rst,
    input  logic             p_flush,
    // issue side
    input  logic             p_inValid,
    output logic             p_inReady,
    input  logic [2:0]       p_op,
    input  logic [WIDTH-1:0] p_srcA,
    input  logic [WIDTH-1:0] p_srcB,
    input  logic [TAG_W-1:0] p_tagIn,
    // external adder
    output logic [WIDTH-1:0] p_addA,
    output logic [WIDTH-1:0] p_addB,
    output logic             p_addCI,
    input  logic [WIDTH-1:0] p_addR,
    input  logic             p_addCO,
    input  logic             p_addOVL,
    // writeback side
    output logic             p_outValid,
    input  logic             p_outReady,
    output logic [WIDTH-1:0] p_result,
    output logic             p_carry,
    output logic             p_ovfTrap,
    output logic             p_wbEn,
    output logic [TAG_W-1:0] p_tagOut
);

    // op field decode: [2]=64-bit, [1]=subtract, [0]=unsigned (never traps)
    localparam int OP_DW  = 2;
    localparam int OP_SUB = 1;
    localparam int OP_UNS = 0;

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_ci_q, s1_ci_d;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    // S2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_carry_q, s2_carry_d;
    logic             s2_trap_q, s2_trap_d;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_adv;
    logic             in_fire;
    logic             ovf;
    logic [WIDTH-1:0] b_ext;

    // Handshake: S1 moves on when S2 is empty or is being drained this cycle
    assign s2_adv    = s1_valid_q & (~s2_valid_q | p_outReady);
    assign p_inReady = ~s1_valid_q | s2_adv;
    assign in_fire   = p_inValid & p_inReady;

    // Operand preparation: sign-extend 32-bit operands, invert B for subtract
    always_comb begin
        // NOTE: every always_comb output is assigned first so no path leaves it unassigned (no latch).
        s1_a_d = p_srcA;
        b_ext  = p_srcB;
        if (!p_op[OP_DW]) begin
            s1_a_d = {{(WIDTH-32){p_srcA[31]}}, p_srcA[31:0]};
            b_ext  = {{(WIDTH-32){p_srcB[31]}}, p_srcB[31:0]};
        end
        s1_b_d  = p_op[OP_SUB] ? ~b_ext : b_ext;
        s1_ci_d = p_op[OP_SUB];
    end

    // Result shaping: 32-bit ops take overflow and carry from bit 32 of the 64-bit sum
    always_comb begin
        s2_result_d = p_addR;
        s2_carry_d  = p_addCO;
        ovf         = p_addOVL;
        if (!s1_op_q[OP_DW]) begin
            s2_result_d = {{(WIDTH-32){p_addR[31]}}, p_addR[31:0]};
            ovf         = p_addR[32] ^ p_addR[31];
            // carry into bit 32 is the carry-out of the low 32-bit add
            s2_carry_d  = p_addR[32] ^ s1_a_q[32] ^ s1_b_q[32];
        end
        s2_trap_d = ovf & ~s1_op_q[OP_UNS] & TRAP_EN;
    end

    // Valid bits: flush kills both stages, but a same-cycle output handshake still completes
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (p_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_d = 1'b1;
            end else if (s2_adv) begin
                s1_valid_d = 1'b0;
            end
            if (s2_adv) begin
                s2_valid_d = 1'b1;
            end else if (p_outReady) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // Pipeline valid registers
    always_ff @(posedge p_clk or posedge p_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (p_rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S1 operand registers, loaded on every accepted issue
    always_ff @(posedge p_clk or posedge p_rst) begin
        // NOTE: data registers are reset as well, so the result/tag outputs read zero after reset.
        if (p_rst) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_ci_q  <= 1'b0;
            s1_op_q  <= '0;
            s1_tag_q <= '0;
        end else if (in_fire) begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_ci_q  <= s1_ci_d;
            s1_op_q  <= p_op;
            s1_tag_q <= p_tagIn;
        end
    end

    // S2 result registers, held while the consumer stalls
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            s2_result_q <= '0;
            s2_carry_q  <= 1'b0;
            s2_trap_q   <= 1'b0;
            s2_tag_q    <= '0;
        end else if (s2_adv) begin
            s2_result_q <= s2_result_d;
            s2_carry_q  <= s2_carry_d;
            s2_trap_q   <= s2_trap_d;
            s2_tag_q    <= s1_tag_q;
        end
    end

    assign p_addA     = s1_a_q;
    assign p_addB     = s1_b_q;
    assign p_addCI    = s1_ci_q;

    // Trap and write-enable are qualified by valid, so a trap is seen only with its op
    assign p_outValid = s2_valid_q;
    assign p_result   = s2_result_q;
    assign p_carry    = s2_carry_q;
    assign p_ovfTrap  = s2_valid_q & s2_trap_q;
    assign p_wbEn     = s2_valid_q & ~s2_trap_q;
    assign p_tagOut   = s2_tag_q;

endmodule

// File: tb/tb_add_sub_exec.sv
// Self-checking bench for add_sub_exec.
// The bench supplies the external adder and a scoreboard of expected results.
// Expected results are computed with plain signed and unsigned arithmetic from the op semantics.
module tb_add_sub_exec;

    localparam int WIDTH = 64;
    localparam int TAG_W = 5;

    logic             p_clk = 1'b0;
    logic             p_rst;
    logic             p_flush;
    logic             p_inValid;
    logic             p_inReady;
    logic [2:0]       p_op;
    logic [WIDTH-1:0] p_srcA, p_srcB;
    logic [TAG_W-1:0] p_tagIn;
    logic [WIDTH-1:0] p_addA, p_addB, p_addR;
    logic             p_addCI, p_addCO, p_addOVL;
    logic             p_outValid, p_outReady;
    logic [WIDTH-1:0] p_result;
    logic             p_carry, p_ovfTrap, p_wbEn;
    logic [TAG_W-1:0] p_tagOut;

    add_sub_exec #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TRAP_EN(1'b1)) dut (
        .p_clk(p_clk), .p_rst(p_rst), .p_flush(p_flush),
        .p_inValid(p_inValid), .p_inReady(p_inReady), .p_op(p_op),
        .p_srcA(p_srcA), .p_srcB(p_srcB), .p_tagIn(p_tagIn),
        .p_addA(p_addA), .p_addB(p_addB), .p_addCI(p_addCI),
        .p_addR(p_addR), .p_addCO(p_addCO), .p_addOVL(p_addOVL),
        .p_outValid(p_outValid), .p_outReady(p_outReady),
        .p_result(p_result), .p_carry(p_carry), .p_ovfTrap(p_ovfTrap),
        .p_wbEn(p_wbEn), .p_tagOut(p_tagOut)
    );

    always #5 p_clk = ~p_clk;

    // External combinational adder: 64-bit sum, carry-out, signed overflow
    logic [64:0] add_sum;
    assign add_sum  = {1'b0, p_addA} + {1'b0, p_addB} + {64'd0, p_addCI};
    assign p_addR   = add_sum[63:0];
    assign p_addCO  = add_sum[64];
    assign p_addOVL = (p_addA[63] == p_addB[63]) && (add_sum[63] != p_addA[63]);

    typedef struct {
        logic [63:0] result;
        logic        carry;
        logic        trap;
        logic [4:0]  tag;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_cycs[$];
    int         out_cycs[$];
    logic [4:0] out_tags[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: op semantics from plain arithmetic on the architectural operands
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] tag);
        exp_t               e;
        logic               ovf;
        logic signed [64:0] s64;
        logic signed [32:0] s32;
        logic [31:0]        r32;
        if (op[2]) begin
            e.result = op[1] ? a - b : a + b;
            e.carry  = op[1] ? (a >= b) : (({1'b0, a} + {1'b0, b}) >= 65'h1_0000_0000_0000_0000);
            s64      = op[1] ? $signed({a[63], a}) - $signed({b[63], b})
                             : $signed({a[63], a}) + $signed({b[63], b});
            ovf      = (s64 > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s64 < -65'sh0_8000_0000_0000_0000);
        end else begin
            r32      = op[1] ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
            e.result = {{32{r32[31]}}, r32};
            e.carry  = op[1] ? (a[31:0] >= b[31:0])
                             : (({1'b0, a[31:0]} + {1'b0, b[31:0]}) >= 33'h1_0000_0000);
            s32      = op[1] ? $signed({a[31], a[31:0]}) - $signed({b[31], b[31:0]})
                             : $signed({a[31], a[31:0]}) + $signed({b[31], b[31:0]});
            ovf      = (s32 > 33'sh0_7FFF_FFFF) || (s32 < -33'sh0_8000_0000);
        end
        e.trap = ovf && !op[0];
        e.tag  = tag;
        return e;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 9))
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return 64'h0000_0000_7FFF_FFFF;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            5:       return 64'h8000_0000_0000_0000;
            6:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // One clock cycle: drive at negedge, then observe handshakes mid-cycle
    task automatic step(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic rdy, input logic fl);
        exp_t e;
        @(negedge p_clk);
        p_inValid  = v;
        p_op       = op;
        p_srcA     = a;
        p_srcB     = b;
        p_tagIn    = tag;
        p_outReady = rdy;
        p_flush    = fl;
        #1;
        if (p_outValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", p_outValid, 1'b0);
            end else begin
                e = exp_q[0];
                check("result", p_result, e.result);
                check("carry", p_carry, e.carry);
                check("ovfTrap", p_ovfTrap, e.trap);
                check("wbEn", p_wbEn, !e.trap);
                check("tagOut", p_tagOut, e.tag);
                if (p_outReady) begin
                    out_cycs.push_back(cyc);
                    out_tags.push_back(p_tagOut);
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            check("idle_trap", p_ovfTrap, 1'b0);
            check("idle_wbEn", p_wbEn, 1'b0);
        end
        if (p_flush) begin
            exp_q.delete();
        end else if (p_inValid && p_inReady) begin
            exp_q.push_back(model(op, a, b, tag));
            acc_cycs.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 3'b000, 64'd0, 64'd0, 5'd0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_empty", exp_q.size(), 0);
        idle(1'b1);
    endtask

    // Issue one op into an empty pipe and check the spec's worked values
    task automatic one_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] er, input logic ec, input logic et);
        bit seen = 0;
        drain();
        step(1'b1, op, a, b, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 6 && !seen; i++) begin
            idle(1'b1);
            if (p_outValid) begin
                seen = 1;
                check({name, "_result"}, p_result, er);
                check({name, "_carry"}, p_carry, ec);
                check({name, "_trap"}, p_ovfTrap, et);
                check({name, "_wbEn"}, p_wbEn, !et);
            end
        end
        if (!seen) check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        p_rst = 1'b1; p_flush = 1'b0; p_inValid = 1'b0; p_op = '0;
        p_srcA = '0; p_srcB = '0; p_tagIn = '0; p_outReady = 1'b0;
        repeat (3) @(negedge p_clk);
        p_rst = 1'b0;
        #1;
        check("rst_outValid", p_outValid, 1'b0);
        check("rst_inReady", p_inReady, 1'b1);
        check("rst_result", p_result, 64'd0);
        check("rst_carry", p_carry, 1'b0);
        check("rst_trap", p_ovfTrap, 1'b0);
        check("rst_wbEn", p_wbEn, 1'b0);
        check("rst_tag", p_tagOut, 5'd0);

        // Directed arithmetic corners
        one_op("dadd_ovf", 3'b100, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        one_op("add_ovf", 3'b000, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
        one_op("addu", 3'b001, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
        one_op("subu", 3'b011, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        one_op("dsub", 3'b110, 64'd5, 64'd3, 64'd2, 1'b1, 1'b0);
        one_op("sub_ovf", 3'b010, 64'h8000_0000, 64'd1, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1);
        one_op("dsubu", 3'b111, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);

        // Back-to-back throughput and latency
        drain();
        acc_cycs.delete(); out_cycs.delete(); out_tags.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 3'b101, rnd_val(), rnd_val(), 5'(10 + i), 1'b1, 1'b0);
        repeat (4) idle(1'b1);
        check("b2b_accepts", acc_cycs.size(), 4);
        check("b2b_outputs", out_cycs.size(), 4);
        if (acc_cycs.size() == 4 && out_cycs.size() == 4) begin
            check("b2b_latency", out_cycs[0] - acc_cycs[0], 2);
            for (int i = 1; i < 4; i++) begin
                check("b2b_consecutive", out_cycs[i] - out_cycs[0], i);
                check("b2b_tag_order", out_tags[i], 5'(10 + i));
            end
        end

        // Consumer stall: third op must be blocked after two accepts
        drain();
        acc_cycs.delete();
        step(1'b1, 3'b000, 64'd100, 64'd1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 3'b010, 64'd100, 64'd1, 5'd2, 1'b0, 1'b0);
        step(1'b1, 3'b100, 64'd7, 64'd8, 5'd3, 1'b0, 1'b0);
        check("stall_accepts", acc_cycs.size(), 2);
        check("stall_inReady", p_inReady, 1'b0);
        for (int i = 0; i < 6 && acc_cycs.size() < 3; i++) step(1'b1, 3'b100, 64'd7, 64'd8, 5'd3, 1'b1, 1'b0);
        check("stall_third_accepted", acc_cycs.size(), 3);
        drain();

        // Flush with both stages full
        step(1'b1, 3'b000, 64'd1, 64'd2, 5'd4, 1'b0, 1'b0);
        step(1'b1, 3'b000, 64'd3, 64'd4, 5'd5, 1'b0, 1'b0);
        step(1'b1, 3'b000, 64'd5, 64'd6, 5'd6, 1'b0, 1'b1);
        idle(1'b1);
        check("flush_outValid", p_outValid, 1'b0);
        check("flush_inReady", p_inReady, 1'b1);

        // Flush while the output handshake completes in the same cycle
        step(1'b1, 3'b100, 64'd9, 64'd1, 5'd8, 1'b0, 1'b0);
        step(1'b1, 3'b100, 64'd9, 64'd2, 5'd9, 1'b0, 1'b0);
        step(1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b1);
        idle(1'b1);
        check("flush_hs_outValid", p_outValid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        drain();

        // Asynchronous reset with both stages full
        step(1'b1, 3'b110, 64'd5, 64'd3, 5'd17, 1'b0, 1'b0);
        step(1'b1, 3'b110, 64'd9, 64'd3, 5'd18, 1'b0, 1'b0);
        @(negedge p_clk);
        p_inValid = 1'b0;
        #3;
        check("pre_rst_outValid", p_outValid, 1'b1);
        p_rst = 1'b1;
        #1;
        check("arst_outValid", p_outValid, 1'b0);
        check("arst_wbEn", p_wbEn, 1'b0);
        check("arst_trap", p_ovfTrap, 1'b0);
        check("arst_result", p_result, 64'd0);
        check("arst_tag", p_tagOut, 5'd0);
        exp_q.delete();
        @(negedge p_clk);
        p_rst = 1'b0;
        #1;
        check("arst_inReady", p_inReady, 1'b1);
        repeat (3) idle(1'b1);
        one_op("post_rst", 3'b110, 64'd5, 64'd3, 64'd2, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
